// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
package mem_arb_pkg;

  // Arbiter has either no owner or exactly one owner.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Modular increment of a requester index; wraps to 0 after nreq-1.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 32'd1 >= nreq) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so that the
// priority pointer sits at bit 0, take the lowest set bit, then map the
// winner back to its real requester index.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] below;
  logic [PW-1:0]   enc;
  logic [PW:0]     sum;

  // Rotate right by ptr so the highest-priority requester lands on bit 0.
  assign rot = NREQ'({req_i, req_i} >> ptr_i);

  // below[gi] is set when some lower rotated position is also requesting.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_below
      if (gi == 0) begin : g_first
        assign below[gi] = 1'b0;
      end else begin : g_rest
        assign below[gi] = |rot[gi-1:0];
      end
    end
  endgenerate

  // Priority-encode the first rotated request, then rotate the index back.
  always_comb begin
    enc = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (rot[k] && !below[k]) enc = PW'(k);
    end
    sum = {1'b0, enc} + {1'b0, ptr_i};
    if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
    idx_o    = sum[PW-1:0];
    any_o    = |req_i;
    onehot_o = any_o ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin owner of a single memory port. A requester keeps the port for
// one BURST-beat cache line or until it drops its access, then the pointer
// moves past it. One idle cycle always separates two owners so the memory
// sees access deassert between transactions.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  parameter int unsigned AW    = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req_access,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_a,
  input  logic [NREQ*AW-1:0] req_d_w,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     m_a,
  output logic [AW-1:0]     m_d_w,
  output logic              m_access,
  output logic              m_write,
  input  logic              m_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            any_req;
  logic            release_now;

  logic [AW-1:0]   a_arr [NREQ];
  logic [AW-1:0]   d_arr [NREQ];

  // Unpack the flat requester buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*AW +: AW];
      assign d_arr[gi] = req_d_w[gi*AW +: AW];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req_access),
    .ptr_i    (ptr_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (any_req)
  );

  // Owner gives up the port on its last beat or as soon as it drops access.
  assign release_now = !req_access[gidx_q] || (m_ready && (beat_q == LAST_BEAT));

  // State register; reset abandons any in-flight transaction immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      beat_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
    end
  end

  // Next-state: pick a winner when idle, count beats and release when busy.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_BUSY;
          gidx_d  = win_idx;
          beat_d  = '0;
          grant_d = win_oh;
        end
      end
      ARB_BUSY: begin
        if (release_now) begin
          state_d = ARB_IDLE;
          ptr_d   = PW'(rr_next(32'(gidx_q), NREQ));
          beat_d  = '0;
          grant_d = '0;
        end else if (m_ready) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: registered select drives the memory mux and the ready demux.
  always_comb begin
    m_a       = '0;
    m_d_w     = '0;
    m_access  = 1'b0;
    m_write   = 1'b0;
    req_ready = '0;
    if (state_q == ARB_BUSY) begin
      m_a       = a_arr[gidx_q];
      m_d_w     = d_arr[gidx_q];
      m_access  = req_access[gidx_q];
      m_write   = req_write[gidx_q];
      req_ready = grant_q & {NREQ{m_ready}};
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level owner/pointer model.
module tb_mem_rr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 4;
  localparam int unsigned AW    = 32;

  logic               clk = 1'b0;
  logic               clrn = 1'b0;
  logic [NREQ-1:0]    req_access = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*AW-1:0] req_a = '0;
  logic [NREQ*AW-1:0] req_d_w = '0;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      m_a;
  logic [AW-1:0]      m_d_w;
  logic               m_access;
  logic               m_write;
  logic               m_ready = 1'b0;
  logic [NREQ-1:0]    grant;
  logic               busy;

  mem_rr_arbiter #(.NREQ(NREQ), .BURST(BURST), .AW(AW)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .req_access (req_access),
    .req_write  (req_write),
    .req_a      (req_a),
    .req_d_w    (req_d_w),
    .req_ready  (req_ready),
    .m_a        (m_a),
    .m_d_w      (m_d_w),
    .m_access   (m_access),
    .m_write    (m_write),
    .m_ready    (m_ready),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 = none), rotation pointer, beats done.
  int own = -1;
  int ptr_m = 0;
  int beat_m = 0;

  logic [NREQ-1:0] obs_grant;
  logic [NREQ-1:0] obs_ready;
  logic [AW-1:0]   obs_a;
  logic            obs_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output with what the model says the port should show now.
  task automatic check_outputs(input string ph);
    logic [NREQ-1:0] eg, er;
    logic [AW-1:0]   ea, ed;
    logic            eacc, ew;
    eg = '0; er = '0; ea = '0; ed = '0; eacc = 1'b0; ew = 1'b0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      er[own] = m_ready;
      ea      = req_a[own*AW +: AW];
      ed      = req_d_w[own*AW +: AW];
      eacc    = req_access[own];
      ew      = req_write[own];
    end
    check({ph, ".grant"}, 64'(grant), 64'(eg));
    check({ph, ".busy"}, 64'(busy), 64'(own >= 0));
    check({ph, ".req_ready"}, 64'(req_ready), 64'(er));
    check({ph, ".m_access"}, 64'(m_access), 64'(eacc));
    check({ph, ".m_write"}, 64'(m_write), 64'(ew));
    check({ph, ".m_a"}, 64'(m_a), 64'(ea));
    check({ph, ".m_d_w"}, 64'(m_d_w), 64'(ed));
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    if (!clrn) begin
      own = -1; ptr_m = 0; beat_m = 0;
      return;
    end
    if (own < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr_m + k) % NREQ;
        if (req_access[i]) begin
          own = i;
          beat_m = 0;
          $display("grant requester=%0d write=%0d addr=%h t=%0t", i, req_write[i], req_a[i*AW +: AW], $time);
          break;
        end
      end
    end else if (!req_access[own] || (m_ready && beat_m == BURST - 1)) begin
      ptr_m = (own + 1) % NREQ;
      own = -1;
      beat_m = 0;
    end else if (m_ready) begin
      beat_m++;
    end
  endtask

  // Called at a negedge with inputs already set: check, capture, clock.
  task automatic cycle(input string ph);
    #1;
    check_outputs(ph);
    obs_grant = grant;
    obs_ready = req_ready;
    obs_a     = m_a;
    obs_w     = m_write;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic restart();
    #2 clrn = 1'b0;
    own = -1; ptr_m = 0; beat_m = 0;
    #1 check_outputs("rst");
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic idle_all();
    req_access = '0; req_write = '0; m_ready = 1'b0;
    cycle("idle");
    cycle("idle");
  endtask

  initial begin
    int pulses;
    int seen_busy;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] order [$];
    logic [NREQ-1:0] exp_order [4];

    @(negedge clk);
    restart();

    // Single requester, ready every third cycle: four beats then release.
    req_access = 4'b0010;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 3 == 2);
      cycle("single");
      if (obs_ready[1]) pulses++;
      if (pulses > 0 && own < 0) break;
    end
    check("single.pulses", 64'(pulses), 64'd4);
    req_access = 4'b0101; m_ready = 1'b0;
    cycle("single");
    cycle("single");
    check("single.ptr2", 64'(obs_grant), 64'(4'b0100));
    idle_all();

    // Collision held from reset: rotation 0,1,3,0 with idle gaps between.
    req_access = 4'b1011; m_ready = 1'b1;
    restart();
    prev = '0;
    order.delete();
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      cycle("coll");
      if (obs_grant != 0 && prev == 0) order.push_back(obs_grant);
      prev = obs_grant;
    end
    exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    check("coll.count", 64'(order.size()), 64'd4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check($sformatf("coll.order%0d", k), 64'(order[k]), 64'(exp_order[k]));
    idle_all();

    // Early drop: one write word from requester 2.
    restart();
    req_access = 4'b0100; req_write = 4'b0100;
    req_a[2*AW +: AW] = 32'h100;
    req_d_w[2*AW +: AW] = 32'hDEADBEEF;
    cycle("drop");
    cycle("drop");
    check("drop.m_a", 64'(obs_a), 64'h100);
    check("drop.m_write", 64'(obs_w), 64'd1);
    m_ready = 1'b1;
    cycle("drop");
    m_ready = 1'b0; req_access = '0; req_write = '0;
    cycle("drop");
    cycle("drop");
    check("drop.released", 64'(obs_grant), 64'd0);

    // Spurious ready while idle: nothing may respond, pointer stays at 3.
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle("spur");
      check("spur.ready", 64'(obs_ready), 64'd0);
    end
    m_ready = 1'b0; req_access = 4'b1100;
    cycle("spur");
    cycle("spur");
    check("spur.ptr3", 64'(obs_grant), 64'(4'b1000));
    idle_all();

    // Reset in the middle of a burst (beat 2) clears pointer and owner.
    req_access = 4'b0001; m_ready = 1'b1;
    seen_busy = 0;
    for (int c = 0; c < 20; c++) begin
      cycle("mid");
      if (own >= 0) seen_busy = 1;
      if (seen_busy != 0 && own < 0) break;
    end
    req_access = 4'b0100; m_ready = 1'b0;
    cycle("mid");
    m_ready = 1'b1;
    cycle("mid");
    cycle("mid");
    m_ready = 1'b0;
    check("mid.owner2", 64'(obs_grant), 64'(4'b0100));
    restart();
    req_access = 4'b0101;
    cycle("mid");
    cycle("mid");
    check("mid.ptr0", 64'(obs_grant), 64'(4'b0001));
    idle_all();

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_access[i]) begin
          if ($urandom_range(15) == 0) req_access[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req_access[i] = 1'b1;
        end
        req_write[i] = 1'($urandom_range(1));
        req_a[i*AW +: AW] = $urandom();
        req_d_w[i*AW +: AW] = $urandom();
      end
      m_ready = ($urandom_range(2) == 0);
      if ($urandom_range(299) == 0) restart();
      else cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
